dsc_mul_bist: RTL and testbench
===============================

# dsc_mul_bist

Synthesizable built-in self-test controller for the 3-input deterministic stochastic multiplier (`dsc_mul`). It drives the `dsc_mul` operand/handshake ports and runs `NUM_TESTS` pseudo-random multiplications. For each test it compares the `dsc_mul` result against an exact product from an internal sequential shift-add multiplier, and it accumulates error and cycle-count statistics. It sits beside `dsc_mul` on silicon/FPGA and does in hardware what the simulation bench does.

## Interface
- `NUM_BITS`, default 10: operand width. Constraint: 3*NUM_BITS ≤ 32.
- `NUM_TESTS`, default 1000: number of multiplications per run. Must be ≥ 1.
- `CNT_W`, default 32: width of the cycle accumulators.
- `TIMEOUT`, default 2**(3*NUM_BITS)+16: maximum number of RUN cycles per test.
- `SEED`, default 32'h1: LFSR seed. A value of 0 is replaced by 1.

Ports (`DUT` = `dsc_mul`):
- `clk`  in  1  — sole clock.
- `rst`  in  1  — asynchronous, active-low reset.
- `start`  in  1  — begin a run. Sampled only in IDLE or DONE.
- `busy`  out  1  — high in every state except IDLE and DONE.
- `done`  out  1  — high while in DONE.
- `pass`  out  1  — valid in DONE. High when `err_count` = 0.
- `dut_rst`  out  1  — active-high reset to the DUT.
- `dut_en`  out  1  — enable to the DUT.
- `dut_a`, `dut_b`, `dut_c`  out  NUM_BITS each — DUT operands.
- `dut_z`  in  3*NUM_BITS  — DUT product.
- `dut_ov`  in  1  — DUT operation-finished flag.
- `test_idx`  out  clog2(NUM_TESTS+1)  — index of the current test.
- `err_count`  out  clog2(NUM_TESTS+1)  — number of mismatches plus timeouts.
- `timeout_seen`  out  1  — sticky flag: some test hit `TIMEOUT`.
- `last_cycles`  out  CNT_W  — RUN cycles used by the most recent test.
- `cycle_total`  out  CNT_W  — sum of `last_cycles` over all tests. Saturates at all-ones.

## Operation
- FSM states: IDLE, LOAD, RUN, SETTLE, CHECK, NEXT, DONE.
- IDLE/DONE + `start` → LOAD.
  - On this transition, clear `test_idx`, `err_count`, `timeout_seen` and `cycle_total`.
  - Reload the LFSR with `SEED`.
- LOAD (1 cycle):
  - Advance the 32-bit Galois LFSR once (taps 32,22,2,1).
  - Latch `dut_a`=lfsr[NUM_BITS-1:0], `dut_b`=next NUM_BITS bits, `dut_c`=next NUM_BITS bits.
  - Drive `dut_rst`=1, `dut_en`=0. Clear the RUN counter. Start the reference multiplier.
- Reference multiplier: computes a*b, then (a*b)*c, shift-add, one partial product per cycle.
  - `mul_done` is raised 2*NUM_BITS cycles after LOAD.
  - Result is 3*NUM_BITS bits wide, with no truncation.
- RUN: `dut_rst`=0, `dut_en`=1. The RUN counter increments every cycle, including the cycle in which `dut_ov` is sampled high.
  - `dut_ov`=1 → SETTLE.
  - Else if RUN counter = `TIMEOUT` → SETTLE with the timeout flag set.
  - If `dut_ov` and the timeout limit occur on the same cycle, `dut_ov` wins: the test is not counted as a timeout.
- SETTLE: `dut_en` stays 1 and the RUN counter is frozen. Stay here until `mul_done`, minimum 1 cycle.
- CHECK (1 cycle):
  - Sample `dut_z` and compare it with the reference product.
  - On mismatch or timeout, increment `err_count`. A timeout also sets `timeout_seen`.
  - `last_cycles` ← RUN count.
  - `cycle_total` += RUN count, saturating.
- NEXT (1 cycle):
  - `dut_rst`=1, `dut_en`=0.
  - If `test_idx` = NUM_TESTS-1 → DONE; else increment `test_idx` → LOAD.
- DONE: hold all statistics. `dut_rst`=1 and `dut_en`=0.
- `start` while `busy` is ignored.

## Timing
- Reset values: state IDLE, `dut_rst`=1, LFSR = SEED. Every other output is 0.
- Reset is asynchronous: `dut_rst` goes high immediately when `rst` falls, even mid-RUN. Nothing is reported for the interrupted test.
- Per-test cycles = 1 (LOAD) + k (RUN) + max(1, residual wait for `mul_done`) + 1 (CHECK) + 1 (NEXT).
  - k is the number of RUN cycles up to and including the one with `dut_ov` high.
  - If k+1 ≥ 2*NUM_BITS, the per-test cost is k+4.
- `start` is sampled at clock edge E; LOAD is the state from edge E. DONE is entered at E + sum of per-test cycles.
- Outputs are registered. `dut_a`/`dut_b`/`dut_c` are stable from LOAD through NEXT.
- `err_count` cannot wrap, because it is sized for NUM_TESTS.

## Test plan
- Reset behaviour: hold `rst`=0 → `dut_rst`=1, `busy`=0, `done`=0, all counters 0. Release reset, no `start` → FSM stays in IDLE indefinitely.
- Clean run:
  - Setup: NUM_TESTS=4; behavioural DUT raises `dut_ov` on its 30th enabled cycle and returns the correct product.
  - Pulse `start`.
  - Required: `done` rises 136 cycles after `start`, `err_count`=0, `pass`=1, `last_cycles`=30, `cycle_total`=120.
- Mismatch: same setup, but the DUT returns product+1 on test 2 → `err_count`=1, `pass`=0, `timeout_seen`=0.
- Timeout: TIMEOUT=100, DUT never asserts `dut_ov`, NUM_TESTS=3 → `err_count`=3, `timeout_seen`=1, `last_cycles`=100, run still completes.
- Boundary: `dut_ov` coincides with RUN count = TIMEOUT → not counted as a timeout. A `start` pulse mid-run does not change `test_idx`.
- Reset mid-operation: drop `rst` during test 1 RUN → `dut_rst`=1 at once. After restart, the operands for test 0 equal those of the first run.

Source files
------------

// File: rtl/dsc_mul_bist.sv
// Built-in self-test for dsc_mul: runs NUM_TESTS LFSR-driven multiplications, checks each against a shift-add reference.
// Per test: LOAD + RUN(k) + SETTLE + CHECK + NEXT cycles; no backpressure, start is ignored while busy.
module dsc_mul_bist #(
  parameter int          NUM_BITS  = 10,
  parameter int          NUM_TESTS = 1000,
  parameter int          CNT_W     = 32,
  parameter int          TIMEOUT   = 2**(3*NUM_BITS)+16,
  parameter logic [31:0] SEED      = 32'h1,
  localparam int         IDX_W     = $clog2(NUM_TESTS+1),
  localparam int         PW        = 3*NUM_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                dut_rst,
  output logic                dut_en,
  output logic [NUM_BITS-1:0] dut_a,
  output logic [NUM_BITS-1:0] dut_b,
  output logic [NUM_BITS-1:0] dut_c,
  input  logic [PW-1:0]       dut_z,
  input  logic                dut_ov,
  output logic [IDX_W-1:0]    test_idx,
  output logic [IDX_W-1:0]    err_count,
  output logic                timeout_seen,
  output logic [CNT_W-1:0]    last_cycles,
  output logic [CNT_W-1:0]    cycle_total
);

  localparam int          RUN_W    = $clog2(TIMEOUT+1);
  localparam int          MC_W     = (NUM_BITS > 1) ? $clog2(2*NUM_BITS) : 1;
  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_CHECK  = 3'd4;
  localparam logic [2:0] S_NEXT   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  logic [2:0]          state, state_nxt;
  logic [31:0]         lfsr, lfsr_src, lfsr_new;
  logic [RUN_W-1:0]    run_cnt, run_inc;
  logic                run_to, hit_to, idle_like, mismatch;
  logic [PW-1:0]       acc, mcand, pp_sum;
  logic [NUM_BITS-1:0] mplier;
  logic [MC_W-1:0]     mul_cnt;
  logic                mul_run, mul_done;
  logic [CNT_W:0]      tot_sum;

  always_comb begin
    idle_like = (state == S_IDLE) || (state == S_DONE);
    lfsr_src  = idle_like ? SEED_EFF : lfsr;
    // Galois form of x^32 + x^22 + x^2 + x + 1
    lfsr_new  = {1'b0, lfsr_src[31:1]} ^ (lfsr_src[0] ? 32'h8020_0003 : 32'h0);
    run_inc   = run_cnt + RUN_W'(1);
    hit_to    = (run_inc == RUN_W'(TIMEOUT));
    pp_sum    = acc + (mplier[0] ? mcand : '0);
    mismatch  = (dut_z != acc);
    tot_sum   = {1'b0, cycle_total} + (CNT_W+1)'(run_cnt);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_LOAD;
      S_LOAD:         state_nxt = S_RUN;
      S_RUN:          if (dut_ov || hit_to) state_nxt = S_SETTLE;
      S_SETTLE:       if (mul_done) state_nxt = S_CHECK;
      S_CHECK:        state_nxt = S_NEXT;
      S_NEXT:         state_nxt = (test_idx == IDX_W'(NUM_TESTS-1)) ? S_DONE : S_LOAD;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      lfsr         <= SEED_EFF;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      dut_rst      <= 1'b1;
      dut_en       <= 1'b0;
      dut_a        <= '0;
      dut_b        <= '0;
      dut_c        <= '0;
      run_cnt      <= '0;
      run_to       <= 1'b0;
      acc          <= '0;
      mcand        <= '0;
      mplier       <= '0;
      mul_cnt      <= '0;
      mul_run      <= 1'b0;
      mul_done     <= 1'b0;
      test_idx     <= '0;
      err_count    <= '0;
      timeout_seen <= 1'b0;
      last_cycles  <= '0;
      cycle_total  <= '0;
    end else begin
      state <= state_nxt;
      busy  <= !((state_nxt == S_IDLE) || (state_nxt == S_DONE));
      done  <= (state_nxt == S_DONE);
      pass  <= (state_nxt == S_DONE) && (err_count == '0);

      if (idle_like && start) begin
        test_idx     <= '0;
        err_count    <= '0;
        timeout_seen <= 1'b0;
        cycle_total  <= '0;
      end

      case (state)
        S_LOAD: begin
          dut_rst <= 1'b0;
          dut_en  <= 1'b1;
        end
        S_RUN: begin
          run_cnt <= run_inc;
          if (!dut_ov && hit_to) run_to <= 1'b1;
        end
        S_CHECK: begin
          if (mismatch || run_to) err_count <= err_count + IDX_W'(1);
          if (run_to) timeout_seen <= 1'b1;
          last_cycles <= CNT_W'(run_cnt);
          cycle_total <= tot_sum[CNT_W] ? '1 : tot_sum[CNT_W-1:0];
          dut_rst     <= 1'b1;
          dut_en      <= 1'b0;
        end
        S_NEXT: if (state_nxt == S_LOAD) test_idx <= test_idx + IDX_W'(1);
        default: ;
      endcase

      // Operands and the reference multiplier are primed on the edge entering LOAD.
      if (state_nxt == S_LOAD) begin
        lfsr     <= lfsr_new;
        dut_a    <= lfsr_new[NUM_BITS-1:0];
        dut_b    <= lfsr_new[2*NUM_BITS-1:NUM_BITS];
        dut_c    <= lfsr_new[3*NUM_BITS-1:2*NUM_BITS];
        dut_rst  <= 1'b1;
        dut_en   <= 1'b0;
        run_cnt  <= '0;
        run_to   <= 1'b0;
        acc      <= '0;
        mcand    <= PW'(lfsr_new[NUM_BITS-1:0]);
        mplier   <= lfsr_new[2*NUM_BITS-1:NUM_BITS];
        mul_cnt  <= '0;
        mul_run  <= 1'b1;
        mul_done <= 1'b0;
      end else if (mul_run) begin
        // The last a*b step hands the finished product over as the multiplicand for c.
        if (mul_cnt == MC_W'(NUM_BITS-1)) begin
          acc    <= '0;
          mcand  <= pp_sum;
          mplier <= dut_c;
        end else begin
          acc    <= pp_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
        end
        mul_cnt <= mul_cnt + MC_W'(1);
        if (mul_cnt == MC_W'(2*NUM_BITS-1)) begin
          mul_run  <= 1'b0;
          mul_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dsc_mul_bist.sv
// Bench for dsc_mul_bist: behavioural dsc_mul with per-test finish cycle and error injection,
// checked against a run-level reference model.
module tb_dsc_mul_bist;
  localparam int          NB   = 10;
  localparam int          NT   = 4;
  localparam int          CW   = 8;
  localparam int          TO   = 100;
  localparam logic [31:0] SEED = 32'h0000_ACE1;
  localparam int          IW   = $clog2(NT+1);
  localparam int          PW   = 3*NB;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, pass, dut_rst, dut_en, dut_ov, timeout_seen;
  logic [NB-1:0] dut_a, dut_b, dut_c;
  logic [PW-1:0] dut_z;
  logic [IW-1:0] test_idx, err_count;
  logic [CW-1:0] last_cycles, cycle_total;

  int n_cmp = 0;
  int n_fail = 0;
  int k_arr[NT];
  int off_arr[NT];
  int en_cnt = 0;

  always #5 clk = ~clk;

  dsc_mul_bist #(.NUM_BITS(NB), .NUM_TESTS(NT), .CNT_W(CW), .TIMEOUT(TO), .SEED(SEED)) u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
    .dut_rst(dut_rst), .dut_en(dut_en), .dut_a(dut_a), .dut_b(dut_b), .dut_c(dut_c),
    .dut_z(dut_z), .dut_ov(dut_ov), .test_idx(test_idx), .err_count(err_count),
    .timeout_seen(timeout_seen), .last_cycles(last_cycles), .cycle_total(cycle_total)
  );

  // Behavioural multiplier: finishes on its k-th enabled cycle (k=0: never), result offset by off.
  always @(posedge clk) begin
    if (dut_rst) en_cnt <= 0;
    else if (dut_en) en_cnt <= en_cnt + 1;
  end

  always_comb begin
    int kk;
    int oo;
    logic [63:0] prod;
    kk = 0;
    oo = 0;
    if (int'(test_idx) < NT) begin
      kk = k_arr[int'(test_idx)];
      oo = off_arr[int'(test_idx)];
    end
    prod   = 64'(dut_a) * 64'(dut_b) * 64'(dut_c);
    dut_z  = prod[PW-1:0] + PW'(oo);
    dut_ov = dut_en && !dut_rst && (kk != 0) && (en_cnt == kk - 1);
  end

  function automatic logic [31:0] galois(input logic [31:0] s);
    logic [31:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 32'h8020_0003;
    return r;
  endfunction

  task automatic set_all(input int k, input int off);
    for (int t = 0; t < NT; t++) begin
      k_arr[t]   = k;
      off_arr[t] = off;
    end
  endtask

  task automatic run_check(input string tag, input int poke);
    logic [31:0] st;
    logic [NB-1:0] ea[NT], eb[NT], ec[NT];
    logic [IW-1:0] idx_b;
    int e_err, e_last, e_tot, e_cost, cyc, last, idx, run;
    bit e_to, to_t;
    st = SEED; e_err = 0; e_last = 0; e_tot = 0; e_cost = 0; e_to = 0; idx_b = '0;
    for (int t = 0; t < NT; t++) begin
      st = galois(st);
      ea[t] = st[NB-1:0];
      eb[t] = st[2*NB-1:NB];
      ec[t] = st[3*NB-1:2*NB];
      to_t  = (k_arr[t] == 0) || (k_arr[t] > TO);
      run   = to_t ? TO : k_arr[t];
      if (to_t) e_to = 1;
      if (to_t || off_arr[t] != 0) e_err++;
      e_last = run;
      e_tot  = (e_tot + run > 2**CW - 1) ? 2**CW - 1 : e_tot + run;
      e_cost += 3 + run + ((2*NB - run > 1) ? 2*NB - run : 1);
    end

    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    cyc = 0; last = -1;
    while (done !== 1'b1 && cyc < 3000) begin
      idx = int'(test_idx);
      if (busy === 1'b1 && idx != last && idx < NT) begin
        n_cmp++;
        if ({dut_a, dut_b, dut_c} !== {ea[idx], eb[idx], ec[idx]}) begin
          n_fail++;
          $display("FAIL %s operands[%0d]: got %h/%h/%h want %h/%h/%h", tag, idx,
                   dut_a, dut_b, dut_c, ea[idx], eb[idx], ec[idx]);
        end
        last = idx;
      end
      if (cyc == poke) begin idx_b = test_idx; start = 1'b1; end
      @(posedge clk); #1; cyc++;
      if (cyc == poke + 1) begin
        start = 1'b0;
        n_cmp++;
        if (test_idx !== idx_b || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL %s start_while_busy: idx %0d busy %b want idx %0d busy 1", tag, test_idx, busy, idx_b);
        end
      end
    end

    n_cmp++;
    if (done !== 1'b1 || cyc != e_cost) begin
      n_fail++;
      $display("FAIL %s done_latency: got %0d (done=%b) want %0d", tag, cyc, done, e_cost);
    end
    n_cmp++;
    if (err_count !== IW'(e_err)) begin n_fail++; $display("FAIL %s err_count: got %0d want %0d", tag, err_count, e_err); end
    n_cmp++;
    if (pass !== (e_err == 0)) begin n_fail++; $display("FAIL %s pass: got %b want %b", tag, pass, e_err == 0); end
    n_cmp++;
    if (timeout_seen !== e_to) begin n_fail++; $display("FAIL %s timeout_seen: got %b want %b", tag, timeout_seen, e_to); end
    n_cmp++;
    if (last_cycles !== CW'(e_last)) begin n_fail++; $display("FAIL %s last_cycles: got %0d want %0d", tag, last_cycles, e_last); end
    n_cmp++;
    if (cycle_total !== CW'(e_tot)) begin n_fail++; $display("FAIL %s cycle_total: got %0d want %0d", tag, cycle_total, e_tot); end
    n_cmp++;
    if (busy !== 1'b0 || dut_rst !== 1'b1 || dut_en !== 1'b0 || test_idx !== IW'(NT-1)) begin
      n_fail++;
      $display("FAIL %s done_state: busy %b rst %b en %b idx %0d want 0 1 0 %0d", tag, busy, dut_rst, dut_en, test_idx, NT-1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (dut_rst !== 1'b1 || dut_en !== 1'b0) begin n_fail++; $display("FAIL reset dut_rst/en: got %b/%b want 1/0", dut_rst, dut_en); end
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin n_fail++; $display("FAIL reset flags: busy %b done %b pass %b want 0", busy, done, pass); end
    n_cmp++;
    if (test_idx !== '0 || err_count !== '0 || timeout_seen !== 1'b0) begin
      n_fail++; $display("FAIL reset counters: idx %0d err %0d to %b want 0", test_idx, err_count, timeout_seen);
    end
    n_cmp++;
    if (last_cycles !== '0 || cycle_total !== '0 || {dut_a, dut_b, dut_c} !== '0) begin
      n_fail++; $display("FAIL reset stats: last %0d total %0d ops %h want 0", last_cycles, cycle_total, {dut_a, dut_b, dut_c});
    end
    @(negedge clk); rst = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || dut_rst !== 1'b1) begin
      n_fail++; $display("FAIL idle_hold: busy %b done %b dut_rst %b want 0 0 1", busy, done, dut_rst);
    end
  endtask

  task automatic test_clean();
    set_all(30, 0);
    run_check("clean", -1);
  endtask

  task automatic test_mismatch();
    set_all(30, 0);
    off_arr[2] = 1;
    run_check("mismatch", -1);
  endtask

  task automatic test_timeout();
    set_all(0, 0);
    run_check("timeout", -1);
  endtask

  task automatic test_boundary();
    set_all(30, 0);
    k_arr[0] = TO; k_arr[1] = TO - 1; k_arr[2] = TO + 1; k_arr[3] = TO;
    run_check("boundary", -1);
    set_all(30, 0);
    run_check("start_busy", 45);
  endtask

  task automatic test_reset_mid();
    int w;
    set_all(30, 0);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    w = 0;
    while (!(test_idx == IW'(1) && dut_en === 1'b1) && w < 500) begin @(posedge clk); #1; w++; end
    #2; rst = 1'b0; #1;
    n_cmp++;
    if (w >= 500 || dut_rst !== 1'b1 || dut_en !== 1'b0 || busy !== 1'b0 || test_idx !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: wait %0d dut_rst %b en %b busy %b idx %0d want 1 0 0 0", w, dut_rst, dut_en, busy, test_idx);
    end
    @(negedge clk); rst = 1'b1;
    run_check("after_reset", -1);
  endtask

  task automatic test_random();
    int r;
    for (int it = 0; it < 6; it++) begin
      for (int t = 0; t < NT; t++) begin
        r = $urandom_range(0, 9);
        k_arr[t]   = (r == 0) ? 0 : (r == 1) ? $urandom_range(TO - 2, TO + 2) : $urandom_range(1, 40);
        off_arr[t] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
      end
      run_check("random", -1);
    end
  endtask

  initial begin
    set_all(30, 0);
    test_reset();
    test_clean();
    test_mismatch();
    test_timeout();
    test_boundary();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
